// File: rtl/timer_dev.sv
// timer_dev: memory-mapped 32-bit countdown timer with one-shot/auto-reload interrupt
module timer_dev (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  Addr,
  input  logic        Wen,
  input  logic [31:0] Din,
  output logic [31:0] DOut,
  output logic        IRQ
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;
  state_t      r_state, w_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset, r_count;
  logic        w_wr, w_wr_ctrl, w_wr_pre, w_en, w_reload, w_zero, w_expire;
  assign w_wr_ctrl = Wen && (Addr == 2'd0);
  assign w_wr_pre  = Wen && (Addr == 2'd1);
  assign w_wr      = w_wr_ctrl || w_wr_pre;
  assign w_en      = r_ctrl[0];
  assign w_reload  = r_ctrl[2:1] == 2'b01;
  assign w_zero    = r_count == 32'd0;
  assign w_expire  = (r_state == S_CNT) && w_en && w_zero;
  assign IRQ       = (r_state == S_INT) && r_ctrl[3];
  assign DOut      = (Addr == 2'd0) ? {28'd0, r_ctrl} :
                     (Addr == 2'd1) ? r_preset :
                     (Addr == 2'd2) ? r_count : 32'd0;
  // next state: a bus write to CTRL/PRESET overrides every other transition
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  w_next = w_en ? S_LOAD : S_IDLE;
      S_LOAD:  w_next = S_CNT;
      S_CNT:   w_next = !w_en ? S_IDLE : (w_zero ? S_INT : S_CNT);
      S_INT:   w_next = (w_reload && w_en) ? S_LOAD : S_INT;
      default: w_next = S_IDLE;
    endcase
    if (w_wr) w_next = S_IDLE;
  end
  // state register
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  // CTRL: bus write, or EN auto-clear when a one-shot count expires
  always_ff @(posedge clk or negedge reset)
    if (!reset)                              r_ctrl    <= 4'd0;
    else if (w_wr_ctrl)                      r_ctrl    <= Din[3:0];
    else if (!w_wr && w_expire && !w_reload) r_ctrl[0] <= 1'b0;
  // PRESET: plain read/write register
  always_ff @(posedge clk or negedge reset)
    if (!reset)        r_preset <= 32'd0;
    else if (w_wr_pre) r_preset <= Din;
  // COUNT: reload in LOAD, guarded decrement in CNT, frozen on a bus write edge
  always_ff @(posedge clk or negedge reset)
    if (!reset) r_count <= 32'd0;
    else if (!w_wr) begin
      if (r_state == S_LOAD)                         r_count <= r_preset;
      else if (r_state == S_CNT && w_en && !w_zero) r_count <= r_count - 32'd1;
    end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: scoreboard bench for timer_dev with directed, hand-computed vectors
module tb_timer_dev;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [1:0]  Addr = 2'd0;
  logic        Wen = 1'b0;
  logic [31:0] Din = 32'd0;
  logic [31:0] DOut;
  logic        IRQ;
  int checks = 0;
  int failures = 0;
  typedef struct {
    bit          is_irq;
    logic [31:0] val;
    string       nm;
  } exp_t;
  exp_t q[$];
  event smp;
  timer_dev dut (.clk(clk), .reset(reset), .Addr(Addr), .Wen(Wen), .Din(Din), .DOut(DOut), .IRQ(IRQ));
  always #10 clk = ~clk;
  // monitor: pops the expected response whenever a sample is presented
  initial forever begin
    @(smp);
    if (q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL underflow: sample with empty scoreboard");
    end else begin
      exp_t e;
      logic [31:0] act;
      e = q.pop_front();
      act = e.is_irq ? {31'd0, IRQ} : DOut;
      checks++;
      if (act !== e.val) begin
        failures++;
        $display("FAIL %s: got 0x%08h expected 0x%08h", e.nm, act, e.val);
      end
    end
  end
  task automatic chk(input logic [1:0] a, input logic [31:0] v, input string nm);
    exp_t e;
    Addr = a;
    #1;
    e.is_irq = 1'b0; e.val = v; e.nm = nm;
    q.push_back(e);
    ->smp;
    #1;
  endtask
  task automatic chk_irq(input logic v, input string nm);
    exp_t e;
    #1;
    e.is_irq = 1'b1; e.val = {31'd0, v}; e.nm = nm;
    q.push_back(e);
    ->smp;
    #1;
  endtask
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    Wen = 1'b1; Addr = a; Din = d;
    @(negedge clk);
    Wen = 1'b0;
  endtask
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask
  initial begin
    idle(2);
    chk(2'd0, 32'd0, "rst_ctrl");
    chk(2'd2, 32'd0, "rst_count");
    chk_irq(1'b0, "rst_irq");
    reset = 1'b1;
    idle(1);
    // register access
    wr(2'd1, 32'h5);
    chk(2'd1, 32'h5, "preset_rd");
    wr(2'd0, 32'hFFFF_FFF0);
    chk(2'd0, 32'h0, "ctrl_mask");
    wr(2'd2, 32'h1234);
    chk(2'd2, 32'h0, "count_ro");
    wr(2'd3, 32'hDEAD_BEEF);
    chk(2'd3, 32'h0, "rsvd_rd");
    // one-shot, N=5: IRQ after E0+8, EN clears at E8
    wr(2'd0, 32'h9);
    idle(1);
    chk(2'd2, 32'h0, "os_load_count");
    idle(1);
    chk(2'd2, 32'h5, "os_count_n");
    idle(5);
    chk(2'd2, 32'h0, "os_count_zero");
    chk(2'd0, 32'h9, "os_ctrl_pre");
    chk_irq(1'b0, "os_irq_pre");
    idle(1);
    chk_irq(1'b1, "os_irq_rise");
    chk(2'd0, 32'h8, "os_ctrl_post");
    for (int k = 0; k < 20; k++) begin
      idle(1);
      chk_irq(1'b1, "os_irq_held");
    end
    wr(2'd0, 32'h8);
    chk_irq(1'b0, "os_irq_ack");
    // auto-reload, N=2: period 5, COUNT 2,1,0 between pulses
    wr(2'd1, 32'h2);
    wr(2'd0, 32'hB);
    for (int k = 1; k <= 20; k++) begin
      idle(1);
      chk_irq((k % 5) == 0, "ar_irq");
      chk(2'd2, ((k % 5) == 2) ? 32'd2 : ((k % 5) == 3) ? 32'd1 : 32'd0, "ar_count");
    end
    chk(2'd0, 32'hB, "ar_ctrl_kept");
    wr(2'd0, 32'h0);
    // pause at COUNT=6
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h9);
    idle(6);
    chk(2'd2, 32'd6, "pause_count_pre");
    wr(2'd0, 32'h8);
    chk(2'd2, 32'd6, "pause_count_frozen");
    idle(5);
    chk(2'd2, 32'd6, "pause_count_hold");
    chk_irq(1'b0, "pause_irq");
    // masked one-shot, N=3: INT at E6, IRQ stays low
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h1);
    idle(5);
    chk(2'd0, 32'h1, "mask_ctrl_pre");
    idle(1);
    chk(2'd0, 32'h0, "mask_ctrl_int");
    chk_irq(1'b0, "mask_irq");
    idle(3);
    chk_irq(1'b0, "mask_irq_later");
    chk(2'd2, 32'd0, "mask_count");
    // collision: PRESET write on the edge where CNT sees COUNT==0
    wr(2'd0, 32'h9);
    idle(5);
    chk(2'd2, 32'd0, "col_count_zero");
    wr(2'd1, 32'd7);
    chk_irq(1'b0, "col_irq");
    chk(2'd0, 32'h9, "col_ctrl_en");
    chk(2'd1, 32'd7, "col_preset");
    for (int k = 1; k <= 10; k++) begin
      idle(1);
      chk_irq(k == 10, "col_fire");
    end
    // asynchronous reset mid-count
    wr(2'd1, 32'h10);
    wr(2'd0, 32'h9);
    idle(2);
    chk(2'd2, 32'h10, "ar_pre_count");
    reset = 1'b0;
    chk(2'd0, 32'h0, "arst_ctrl");
    chk(2'd1, 32'h0, "arst_preset");
    chk(2'd2, 32'h0, "arst_count");
    chk_irq(1'b0, "arst_irq");
    idle(1);
    reset = 1'b1;
    idle(4);
    chk(2'd2, 32'h0, "arst_no_resume");
    chk_irq(1'b0, "arst_irq_after");
    idle(1);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
